// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand fetch stage with immediate, direct, indirect, indexed
//               and implied addressing over a one-cycle-latency data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] Instr_in,
  input  logic [2:0] AddrMode_in,
  input  logic [8:0] Data_in,
  input  logic [7:0] index_in,
  output logic [7:0] DRAM_addr,
  output logic       DRAM_read_en,
  input  logic [7:0] DRAM_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] Instr_out,
  output logic [7:0] Operand_out,
  output logic [7:0] EffAddr_out,
  output logic       Ext_out,
  output logic       illegal_out
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD1  = 3'd1;
  localparam logic [2:0] CAP1 = 3'd2;
  localparam logic [2:0] RD2  = 3'd3;
  localparam logic [2:0] CAP2 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [2:0] MODE_IMM = 3'd0;
  localparam logic [2:0] MODE_DIR = 3'd1;
  localparam logic [2:0] MODE_IND = 3'd2;
  localparam logic [2:0] MODE_IDX = 3'd3;
  localparam logic [2:0] MODE_IMP = 3'd4;

  logic [2:0] r_state;
  logic       r_indirect;
  logic [7:0] r_dramAddr;
  logic       r_readEn;
  logic       r_outValid;
  logic [4:0] r_instr;
  logic [7:0] r_operand;
  logic [7:0] r_effAddr;
  logic       r_ext;
  logic       r_illegal;
  logic [7:0] w_idxAddr;

  assign w_idxAddr    = Data_in[7:0] + index_in;
  assign in_ready     = (r_state == IDLE) && !reset;
  assign DRAM_addr    = r_dramAddr;
  assign DRAM_read_en = r_readEn;
  assign out_valid    = r_outValid;
  assign Instr_out    = r_instr;
  assign Operand_out  = r_operand;
  assign EffAddr_out  = r_effAddr;
  assign Ext_out      = r_ext;
  assign illegal_out  = r_illegal;

  // Read strobe and address are registered so they are stable for the whole RD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_indirect <= 1'b0;
      r_dramAddr <= 8'd0;
      r_readEn   <= 1'b0;
      r_outValid <= 1'b0;
      r_instr    <= 5'd0;
      r_operand  <= 8'd0;
      r_effAddr  <= 8'd0;
      r_ext      <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_readEn   <= 1'b0;
      r_dramAddr <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_instr    <= Instr_in;
            r_ext      <= Data_in[8];
            r_illegal  <= 1'b0;
            r_operand  <= 8'd0;
            r_effAddr  <= 8'd0;
            r_indirect <= (AddrMode_in == MODE_IND);
            case (AddrMode_in)
              MODE_IMM: begin
                r_operand  <= Data_in[7:0];
                r_outValid <= 1'b1;
                r_state    <= DONE;
              end
              MODE_DIR, MODE_IND: begin
                r_effAddr  <= Data_in[7:0];
                r_dramAddr <= Data_in[7:0];
                r_readEn   <= 1'b1;
                r_state    <= RD1;
              end
              MODE_IDX: begin
                r_effAddr  <= w_idxAddr;
                r_dramAddr <= w_idxAddr;
                r_readEn   <= 1'b1;
                r_state    <= RD1;
              end
              MODE_IMP: begin
                r_outValid <= 1'b1;
                r_state    <= DONE;
              end
              default: begin
                r_illegal  <= 1'b1;
                r_outValid <= 1'b1;
                r_state    <= DONE;
              end
            endcase
          end
        end
        RD1: begin
          r_readEn   <= 1'b0;
          r_dramAddr <= 8'd0;
          r_state    <= CAP1;
        end
        CAP1: begin
          // Indirect: first read returned the pointer, which becomes the effective address.
          if (r_indirect) begin
            r_effAddr  <= DRAM_data;
            r_dramAddr <= DRAM_data;
            r_readEn   <= 1'b1;
            r_state    <= RD2;
          end else begin
            r_operand  <= DRAM_data;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        RD2: begin
          r_readEn   <= 1'b0;
          r_dramAddr <= 8'd0;
          r_state    <= CAP2;
        end
        CAP2: begin
          r_operand  <= DRAM_data;
          r_outValid <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_readEn   <= 1'b0;
          r_dramAddr <= 8'd0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch with a transaction-level
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0] Instr_in, Instr_out;
  logic [2:0] AddrMode_in;
  logic [8:0] Data_in;
  logic [7:0] index_in, DRAM_addr, DRAM_data, Operand_out, EffAddr_out;
  logic       DRAM_read_en, Ext_out, illegal_out;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] mem [256];
  logic [7:0] ramQ;

  operand_fetch dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Instr_in(Instr_in), .AddrMode_in(AddrMode_in), .Data_in(Data_in), .index_in(index_in),
    .DRAM_addr(DRAM_addr), .DRAM_read_en(DRAM_read_en), .DRAM_data(DRAM_data),
    .out_valid(out_valid), .out_ready(out_ready), .Instr_out(Instr_out),
    .Operand_out(Operand_out), .EffAddr_out(EffAddr_out), .Ext_out(Ext_out),
    .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  // Synchronous data RAM, one-cycle read latency
  always @(posedge clk) if (DRAM_read_en) ramQ <= mem[DRAM_addr];
  assign DRAM_data = ramQ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules for a single instruction
  function automatic int latencyOf(input logic [2:0] m);
    if (m == 3'd1 || m == 3'd3) return 3;
    if (m == 3'd2) return 5;
    return 1;
  endfunction

  function automatic logic [7:0] effOf(input logic [2:0] m, input logic [7:0] d, input logic [7:0] i);
    logic [7:0] sum;
    sum = d + i;
    case (m)
      3'd1:    return d;
      3'd2:    return mem[d];
      3'd3:    return sum;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] operandOf(input logic [2:0] m, input logic [7:0] d, input logic [7:0] i);
    case (m)
      3'd0:       return d;
      3'd1, 3'd3: return mem[effOf(m, d, i)];
      3'd2:       return mem[mem[d]];
      default:    return 8'd0;
    endcase
  endfunction

  // Model state: one outstanding instruction and cycles elapsed since its accept
  logic       mBusy;
  int         mK;
  logic [2:0] mMode;
  logic [8:0] mData;
  logic [7:0] mIdx;
  logic [4:0] mInstr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mBusy <= 1'b0;
      mK    <= 0;
    end else if (flush) begin
      mBusy <= 1'b0;
    end else if (!mBusy) begin
      if (in_valid) begin
        mBusy  <= 1'b1;
        mK     <= 1;
        mMode  <= AddrMode_in;
        mData  <= Data_in;
        mIdx   <= index_in;
        mInstr <= Instr_in;
      end
    end else if (mK >= latencyOf(mMode)) begin
      if (out_ready) mBusy <= 1'b0;
    end else begin
      mK <= mK + 1;
    end
  end

  logic       expRd, expValid;
  logic [7:0] expAddr;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_read_en", DRAM_read_en, 0);
      check("rst_addr", DRAM_addr, 0);
      check("rst_operand", Operand_out, 0);
      check("rst_effaddr", EffAddr_out, 0);
      check("rst_instr", Instr_out, 0);
      check("rst_ext", Ext_out, 0);
      check("rst_illegal", illegal_out, 0);
    end else begin
      expRd    = mBusy && latencyOf(mMode) > 1 && (mK == 1 || (mMode == 3'd2 && mK == 3));
      expAddr  = !expRd ? 8'd0 : (mK == 1 ? (mMode == 3'd3 ? effOf(mMode, mData[7:0], mIdx) : mData[7:0])
                                          : mem[mData[7:0]]);
      expValid = mBusy && mK >= latencyOf(mMode);
      check("in_ready", in_ready, !mBusy);
      check("read_en", DRAM_read_en, expRd);
      check("dram_addr", DRAM_addr, expAddr);
      check("out_valid", out_valid, expValid);
      if (expValid) begin
        check("instr_out", Instr_out, mInstr);
        check("operand_out", Operand_out, operandOf(mMode, mData[7:0], mIdx));
        check("ext_out", Ext_out, mData[8]);
        check("illegal_out", illegal_out, mMode > 3'd4);
        if (mMode <= 3'd4) check("effaddr_out", EffAddr_out, effOf(mMode, mData[7:0], mIdx));
      end
    end
  end

  task automatic goIdle();
    flush = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    flush = 1'b0;
  endtask

  task automatic send(input logic [4:0] ins, input logic [2:0] m, input logic [8:0] d, input logic [7:0] i);
    in_valid = 1'b1; Instr_in = ins; AddrMode_in = m; Data_in = d; index_in = i;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  logic       rd [1:5];
  logic [7:0] ad [1:5];
  logic       ov [1:5];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Instr_in = '0; AddrMode_in = '0; Data_in = '0; index_in = '0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Immediate, then backpressure for four cycles
    goIdle();
    out_ready = 1'b0;
    send(5'h03, 3'b000, 9'h1A5, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("imm_valid", out_valid, 1);
      check("imm_operand", Operand_out, 8'hA5);
      check("imm_ext", Ext_out, 1);
      check("imm_illegal", illegal_out, 0);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    @(posedge clk); #2;
    send(5'h1F, 3'b100, 9'h0C3, 8'h00);
    @(negedge clk);
    check("imp_valid", out_valid, 1);
    check("imp_operand", Operand_out, 8'h00);
    check("imp_instr", Instr_out, 5'h1F);

    // Indirect
    goIdle();
    mem[8'h10] = 8'h40; mem[8'h40] = 8'h7E;
    send(5'h07, 3'b010, 9'h010, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rd[c] = DRAM_read_en; ad[c] = DRAM_addr; ov[c] = out_valid;
    end
    check("ind_rd1", {rd[1], ad[1]}, 9'h110);
    check("ind_rd2", rd[2], 0);
    check("ind_rd3", {rd[3], ad[3]}, 9'h140);
    check("ind_valid4", ov[4], 0);
    check("ind_valid5", ov[5], 1);
    check("ind_operand", Operand_out, 8'h7E);
    check("ind_effaddr", EffAddr_out, 8'h40);

    // Indexed with wrap
    goIdle();
    mem[8'h10] = 8'h55;
    send(5'h02, 3'b011, 9'h0F0, 8'h20);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ov[c] = out_valid;
    end
    check("idx_valid2", ov[2], 0);
    check("idx_valid3", ov[3], 1);
    check("idx_effaddr", EffAddr_out, 8'h10);
    check("idx_operand", Operand_out, 8'h55);

    // Flush during CAP1 while in_valid is high
    goIdle();
    send(5'h04, 3'b001, 9'h033, 8'h00);
    @(posedge clk); #2;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check("flush_no_valid", out_valid, 0);
      @(negedge clk);
    end

    // Reset asserted during RD2
    @(posedge clk); #2;
    send(5'h06, 3'b010, 9'h010, 8'h00);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rd2_read_en", DRAM_read_en, 1);
    #1 reset = 1'b1;
    #1;
    check("async_read_en", DRAM_read_en, 0);
    check("async_addr", DRAM_addr, 0);
    check("async_valid", out_valid, 0);
    check("async_in_ready", in_ready, 0);
    @(posedge clk); #2 reset = 1'b0;

    // Illegal mode
    out_ready = 1'b0;
    send(5'h09, 3'b110, 9'h1FF, 8'h00);
    @(negedge clk);
    check("ill_valid", out_valid, 1);
    check("ill_flag", illegal_out, 1);
    check("ill_operand", Operand_out, 0);
    check("ill_no_read", DRAM_read_en, 0);

    // Randomized traffic
    goIdle();
    for (int n = 0; n < 800; n++) begin
      in_valid    = 1'($urandom_range(0, 1));
      Instr_in    = 5'($urandom);
      AddrMode_in = 3'($urandom_range(0, 7));
      Data_in     = 9'($urandom);
      index_in    = 8'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have these ports: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-high; clears all state immediately.
REQ-003 SHALL have flush, input, 1, synchronous abort of the in-flight instruction (branch redirect).
REQ-004 SHALL have in_valid, input, 1, and in_ready, output, 1, as the upstream handshake with the stage register.
REQ-005 SHALL have Instr_in, input, 5, opcode; AddrMode_in, input, 3, addressing mode; Data_in, input, 9, operand field.
REQ-006 SHALL have index_in, input, 8, the index register value, sampled at accept.
REQ-007 SHALL have DRAM_addr, output, 8; DRAM_read_en, output, 1; DRAM_data, input, 8, for a synchronous data RAM with one-cycle read latency.
REQ-008 SHALL have out_valid, input-facing output, 1, and out_ready, input, 1, as the downstream handshake with the accumulator ALU.
REQ-009 SHALL have Instr_out, output, 5; Operand_out, output, 8; EffAddr_out, output, 8; Ext_out, output, 1 (Data_in[8] passthrough); illegal_out, output, 1.

Function
REQ-010 SHALL implement the FSM states IDLE, RD1, CAP1, RD2, CAP2 and DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; accept occurs on a rising edge where in_valid=1 and in_ready=1, capturing Instr, mode, Data and index.
REQ-012 SHALL decode the modes as follows:
- 000 immediate: Operand=Data[7:0], EffAddr=0.
- 001 direct: EffAddr=Data[7:0].
- 010 indirect: ptr=DRAM[Data[7:0]], EffAddr=ptr.
- 011 indexed: EffAddr=(Data[7:0]+index) mod 256.
- 100 implied: Operand=0, EffAddr=0.
- 101-111: illegal.
REQ-013 SHALL, for direct and indexed modes, fetch Operand=DRAM[EffAddr].
REQ-014 SHALL, for indirect mode, fetch Operand=DRAM[ptr].
REQ-015 SHALL, for immediate, implied and illegal modes, go IDLE->DONE on accept, with out_valid=1 in cycle 1 after accept; illegal sets illegal_out=1 and Operand=0.
REQ-016 SHALL, for direct and indexed modes, go IDLE->RD1->CAP1->DONE, with out_valid=1 in cycle 3 after accept.
REQ-017 SHALL, for indirect mode, go IDLE->RD1->CAP1->RD2->CAP2->DONE, with out_valid=1 in cycle 5 after accept.
REQ-018 SHALL assert DRAM_read_en only in RD1 and RD2, for exactly one cycle each, with DRAM_addr registered and stable in that cycle; in CAP states it SHALL capture DRAM_data at the clock edge.
REQ-019 SHALL drive DRAM_addr=0 and DRAM_read_en=0 in all other states.
REQ-020 SHALL, in DONE, hold all out_* stable while out_ready=0, and go DONE->IDLE on the edge with out_ready=1.
REQ-021 SHALL only accept a new instruction in a later cycle; peak throughput is one instruction per two cycles.
REQ-022 SHALL clear out_valid in the cycle after the downstream handshake.
REQ-023 SHALL, on flush=1 in any state, go to IDLE at the next edge with out_valid=0 and no accept that cycle; flush has priority over in_valid and out_ready.
REQ-024 SHALL wrap the index addition modulo 256 with no carry output.
REQ-025 SHALL treat Data_in[8] as address-neutral and pass it to Ext_out only.

Reset
REQ-026 SHALL, while reset=1, force state=IDLE and all outputs and registers to 0, except in_ready, which SHALL be 1 once reset is low.
REQ-027 SHALL abandon a DRAM access when reset is asserted mid-operation, driving DRAM_read_en=0 immediately (asynchronously).

Verification
REQ-028 Immediate: accept Instr=5'h03, mode=000, Data=9'h1A5 -> cycle 1 out_valid=1, Operand=8'hA5, Ext_out=1, illegal_out=0.
REQ-029 Indirect: DRAM[8'h10]=8'h40 and DRAM[8'h40]=8'h7E; accept mode=010, Data=8'h10 -> read_en in cycles 1 and 3 at addresses 10 then 40; cycle 5 Operand=7E, EffAddr=40.
REQ-030 Indexed wrap: Data=8'hF0, index=8'h20, DRAM[8'h10]=8'h55 -> EffAddr=10, Operand=55 in cycle 3.
REQ-031 Backpressure: out_ready=0 for 4 cycles in DONE -> outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle, then accept the next instruction.
REQ-032 Flush and reset: flush in CAP1 with in_valid=1 -> IDLE, out_valid never set, no accept; reset asserted in RD2 -> read_en drops at once, all outputs 0.
REQ-033 Illegal mode: mode=110 -> cycle 1 illegal_out=1, Operand=0, no DRAM read.
